// File: rtl/asic_poc_seq_if.sv
// ---------------------------------------------------------------------------
// asic_poc_seq_if
//   Signal bundle between the power-on-control sequencer and its environment
//   (pad sense, software control, pad ring poc pin, core reset tree).
//
//   pwr_good    : async IO-supply-good from the pad sense
//   force_poc   : clk-domain software request to re-run the sequence
//   poc         : power-on control to the IO pads, 1 = pads held safe
//   core_rst    : active-high core reset
//   ready       : sequence complete, core running
//   state       : HOLD=0, WAIT_PG=1, RELEASE=2, RUN=3
//   fault_count : saturating brown-out count
//
//   slave  : sequencer side
//   master : environment side (drives pwr_good / force_poc)
// ---------------------------------------------------------------------------
interface asic_poc_seq_if;
    logic       pwr_good;
    logic       force_poc;
    logic       poc;
    logic       core_rst;
    logic       ready;
    logic [1:0] state;
    logic [7:0] fault_count;

    modport slave (
        input  pwr_good,
        input  force_poc,
        output poc,
        output core_rst,
        output ready,
        output state,
        output fault_count
    );

    modport master (
        output pwr_good,
        output force_poc,
        input  poc,
        input  core_rst,
        input  ready,
        input  state,
        input  fault_count
    );
endinterface

// File: rtl/asic_poc_seq.sv
// ---------------------------------------------------------------------------
// asic_poc_seq
//   Power-on-control sequencer for the IO ring. Holds the pads safe (poc=1)
//   and the core in reset until a debounced supply-good is seen, then drops
//   poc and, RST_CYCLES later, releases the core. Brown-out or a software
//   request returns to HOLD.
//
//   Ports:
//     clk  : single clock
//     rst  : synchronous active-high reset
//     bus  : asic_poc_seq_if.slave (pwr_good, force_poc in;
//            poc, core_rst, ready, state, fault_count out)
//
//   Parameters:
//     POC_CYCLES (>=2) : cycles poc stays asserted after HOLD entry
//     DEBOUNCE   (>=1) : consecutive synchronized pwr_good high cycles
//     RST_CYCLES (>=1) : cycles from poc fall to core reset release
//
//   Build option:
//     ASIC_POC_FAULT_CNT_EN : when defined, fault_count is a saturating
//                             brown-out counter; otherwise it reads 0.
// ---------------------------------------------------------------------------
module asic_poc_seq #(
    parameter int POC_CYCLES = 64,
    parameter int DEBOUNCE   = 8,
    parameter int RST_CYCLES = 16
) (
    input  logic           clk,
    input  logic           rst,
    asic_poc_seq_if.slave  bus
);

    localparam int MAX_AB = (POC_CYCLES > DEBOUNCE) ? POC_CYCLES : DEBOUNCE;
    localparam int MAX_P  = (MAX_AB > RST_CYCLES) ? MAX_AB : RST_CYCLES;
    // cnt never exceeds the largest terminal value, MAX_P-1
    localparam int CW     = (MAX_P > 1) ? $clog2(MAX_P) : 1;

    localparam logic [CW-1:0] POC_TERM = CW'(POC_CYCLES - 1);
    localparam logic [CW-1:0] DEB_TERM = CW'(DEBOUNCE - 1);
    localparam logic [CW-1:0] RST_TERM = CW'(RST_CYCLES - 1);

    typedef enum logic [1:0] {
        HOLD    = 2'd0,
        WAIT_PG = 2'd1,
        RELEASE = 2'd2,
        RUN     = 2'd3
    } state_t;

    logic          sync1_q, sync1_d;
    logic          pg_s_q,  pg_s_d;
    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q,   cnt_d;
    logic          poc_q,      poc_d;
    logic          core_rst_q, core_rst_d;
    logic          ready_q,    ready_d;
    logic          brownout;

    // supply lost while pads are already released
    assign brownout = ((state_q == RELEASE) || (state_q == RUN)) && !pg_s_q;

    always_comb begin
        sync1_d = bus.pwr_good;
        pg_s_d  = sync1_q;
        state_d = state_q;
        cnt_d   = cnt_q;

        if (bus.force_poc) begin
            state_d = HOLD;
            cnt_d   = '0;
        end else if (brownout) begin
            state_d = HOLD;
            cnt_d   = '0;
        end else begin
            case (state_q)
                HOLD: begin
                    if (cnt_q == POC_TERM) begin
                        state_d = WAIT_PG;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                WAIT_PG: begin
                    // any low sample restarts the debounce window
                    if (!pg_s_q) begin
                        cnt_d = '0;
                    end else if (cnt_q == DEB_TERM) begin
                        state_d = RELEASE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                RELEASE: begin
                    if (cnt_q == RST_TERM) begin
                        state_d = RUN;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                RUN: begin
                    cnt_d = '0;
                end
                default: begin
                    state_d = HOLD;
                    cnt_d   = '0;
                end
            endcase
        end

        // outputs decode the next state so they move on the same edge
        poc_d      = (state_d == HOLD) || (state_d == WAIT_PG);
        core_rst_d = (state_d != RUN);
        ready_d    = (state_d == RUN);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q    <= 1'b0;
            pg_s_q     <= 1'b0;
            state_q    <= HOLD;
            cnt_q      <= '0;
            poc_q      <= 1'b1;
            core_rst_q <= 1'b1;
            ready_q    <= 1'b0;
        end else begin
            sync1_q    <= sync1_d;
            pg_s_q     <= pg_s_d;
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            poc_q      <= poc_d;
            core_rst_q <= core_rst_d;
            ready_q    <= ready_d;
        end
    end

`ifdef ASIC_POC_FAULT_CNT_EN
    logic [7:0] fault_q, fault_d;

    // force_poc wins over brown-out, so a forced exit is not a fault
    always_comb begin
        fault_d = fault_q;
        if (brownout && !bus.force_poc && (fault_q != 8'hFF))
            fault_d = fault_q + 8'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) fault_q <= 8'h00;
        else     fault_q <= fault_d;
    end

    assign bus.fault_count = fault_q;
`else
    assign bus.fault_count = 8'h00;
`endif

    assign bus.poc      = poc_q;
    assign bus.core_rst = core_rst_q;
    assign bus.ready    = ready_q;
    assign bus.state    = state_q;

endmodule
